// File: rtl/tag_match_pipe_pkg.sv
// Shared defaults for the tag matcher slice.
// Derived widths and the index encoder stay local to the matcher.
package tag_match_pipe_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_NUM_WAYS   = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

endpackage : tag_match_pipe_pkg

// File: rtl/tag_match_pipe_equal_nbit.sv
// Generic N-bit equality comparator used for the per-way tag compare.
module equal_nbit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq_c
);

    assign eq_c = (a == b);

endmodule : equal_nbit

// File: rtl/tag_match_pipe.sv
// Two-stage masked N-way tag matcher with valid/ready flow control,
// lowest-way encoding and saturating lookup/hit statistics.
module tag_match_pipe
    import tag_match_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_WAYS   = DEF_NUM_WAYS,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [DATA_WIDTH-1:0]          i_key,
    input  logic [DATA_WIDTH-1:0]          i_mask,
    input  logic [NUM_WAYS*DATA_WIDTH-1:0] i_tags,
    input  logic [NUM_WAYS-1:0]            i_tag_valid,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_hit,
    output logic                           o_multi_hit,
    output logic [NUM_WAYS-1:0]            o_way_onehot,
    output logic [$clog2(NUM_WAYS)-1:0]    o_way_idx,
    input  logic                           i_cnt_clr,
    output logic [CNT_WIDTH-1:0]           o_lookup_cnt,
    output logic [CNT_WIDTH-1:0]           o_hit_cnt
);

    localparam int unsigned WAY_IDX_W = $clog2(NUM_WAYS);

    function automatic logic [WAY_IDX_W-1:0] onehot_to_idx(input logic [NUM_WAYS-1:0] oh);
        logic [WAY_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (oh[w]) idx = idx | WAY_IDX_W'(w);
        end
        return idx;
    endfunction

    logic [NUM_WAYS-1:0]   tag_eq;
    logic [NUM_WAYS-1:0]   match_c;
    logic                  s1_valid;
    logic [NUM_WAYS-1:0]   s1_match;
    logic                  s2_valid;
    logic                  s1_en;
    logic                  s2_en;
    logic [NUM_WAYS-1:0]   lowest_c;
    logic                  out_hs;

    // Per-way masked compare; invalid ways are forced to miss.
    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        equal_nbit #(
            .WIDTH (DATA_WIDTH)
        ) u_eq (
            .a    (i_key & i_mask),
            .b    (i_tags[w*DATA_WIDTH +: DATA_WIDTH] & i_mask),
            .eq_c (tag_eq[w])
        );
    end

    assign match_c = tag_eq & i_tag_valid;

    // Bubble-collapsing enables: an empty stage always loads.
    assign s2_en   = ~s2_valid | i_ready;
    assign s1_en   = ~s1_valid | s2_en;
    assign o_ready = s1_en;
    assign o_valid = s2_valid;
    assign out_hs  = s2_valid & i_ready;

    // Two's-complement trick isolates the lowest matching way.
    assign lowest_c = s1_match & (~s1_match + NUM_WAYS'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
        end else if (s1_en) begin
            s1_valid <= i_valid;
            s1_match <= match_c;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid     <= 1'b0;
            o_hit        <= 1'b0;
            o_multi_hit  <= 1'b0;
            o_way_onehot <= '0;
            o_way_idx    <= '0;
        end else if (s2_en) begin
            s2_valid     <= s1_valid;
            o_hit        <= |s1_match;
            // Clearing the lowest set bit leaves something iff two or more matched.
            o_multi_hit  <= |(s1_match & (s1_match - NUM_WAYS'(1)));
            o_way_onehot <= lowest_c;
            o_way_idx    <= onehot_to_idx(lowest_c);
        end
    end

    // Statistics count delivered results; clear beats increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lookup_cnt <= '0;
            o_hit_cnt    <= '0;
        end else if (i_cnt_clr) begin
            o_lookup_cnt <= '0;
            o_hit_cnt    <= '0;
        end else if (out_hs) begin
            if (~&o_lookup_cnt) o_lookup_cnt <= o_lookup_cnt + CNT_WIDTH'(1);
            if (o_hit && ~&o_hit_cnt) o_hit_cnt <= o_hit_cnt + CNT_WIDTH'(1);
        end
    end

endmodule : tag_match_pipe

// File: tb/tb_tag_match_pipe.sv
// Randomised and directed bench for tag_match_pipe against a queue-based
// transaction model of the lookup rules, flow control and statistics.
module tb_tag_match_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned NW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 2;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic               i_clk;
    logic               i_rst_n;
    logic               i_valid;
    logic               o_ready;
    logic [DW-1:0]      i_key;
    logic [DW-1:0]      i_mask;
    logic [NW*DW-1:0]   i_tags;
    logic [NW-1:0]      i_tag_valid;
    logic               o_valid;
    logic               i_ready;
    logic               o_hit;
    logic               o_multi_hit;
    logic [NW-1:0]      o_way_onehot;
    logic [IW-1:0]      o_way_idx;
    logic               i_cnt_clr;
    logic [CW-1:0]      o_lookup_cnt;
    logic [CW-1:0]      o_hit_cnt;

    tag_match_pipe #(
        .DATA_WIDTH (DW),
        .NUM_WAYS   (NW),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_key        (i_key),
        .i_mask       (i_mask),
        .i_tags       (i_tags),
        .i_tag_valid  (i_tag_valid),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_hit        (o_hit),
        .o_multi_hit  (o_multi_hit),
        .o_way_onehot (o_way_onehot),
        .o_way_idx    (o_way_idx),
        .i_cnt_clr    (i_cnt_clr),
        .o_lookup_cnt (o_lookup_cnt),
        .o_hit_cnt    (o_hit_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          hit;
        logic          multi;
        logic [NW-1:0] onehot;
        logic [IW-1:0] idx;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_lookup = 0;
    int   m_hit    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference: scan the ways in order, first hit wins, count every hit.
    function automatic exp_t model(input logic [DW-1:0] key, input logic [DW-1:0] mask,
                                   input logic [NW*DW-1:0] tags, input logic [NW-1:0] tv);
        exp_t e;
        int   hits;
        logic [DW-1:0] t;
        e.hit = 1'b0; e.multi = 1'b0; e.onehot = '0; e.idx = '0; e.cyc = 0;
        hits = 0;
        for (int w = 0; w < NW; w++) begin
            t = tags[w*DW +: DW];
            if (tv[w] && ((key & mask) == (t & mask))) begin
                if (hits == 0) begin
                    e.onehot[w] = 1'b1;
                    e.idx = IW'(w);
                end
                hits++;
            end
        end
        e.hit   = (hits > 0);
        e.multi = (hits >= 2);
        return e;
    endfunction

    // One clock: drive at negedge, check shortly after, predict the next edge.
    task automatic step(input logic v, input logic [DW-1:0] key, input logic [DW-1:0] mask,
                        input logic [NW*DW-1:0] tags, input logic [NW-1:0] tv,
                        input logic rdy, input logic clr, output logic acc);
        exp_t e;
        logic exp_valid;
        i_valid = v; i_key = key; i_mask = mask; i_tags = tags;
        i_tag_valid = tv; i_ready = rdy; i_cnt_clr = clr;
        #1;
        check_val("o_ready", 32'(o_ready), 32'((q.size() >= 2 && !rdy) ? 0 : 1));
        exp_valid = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
        check_val("o_valid", 32'(o_valid), 32'(exp_valid));
        if (o_valid && q.size() > 0) begin
            e = q[0];
            check_val("result", 32'({o_hit, o_multi_hit, o_way_onehot, o_way_idx}),
                      32'({e.hit, e.multi, e.onehot, e.idx}));
        end
        check_val("lookup_cnt", 32'(o_lookup_cnt), 32'(m_lookup));
        check_val("hit_cnt", 32'(o_hit_cnt), 32'(m_hit));
        acc = v & o_ready;
        if (clr) begin
            m_lookup = 0;
            m_hit    = 0;
        end else if (o_valid && rdy && q.size() > 0) begin
            if (m_lookup < CNT_MAX) m_lookup++;
            if (q[0].hit && m_hit < CNT_MAX) m_hit++;
        end
        if (o_valid && rdy && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            e = model(key, mask, tags, tv);
            e.cyc = cyc;
            q.push_back(e);
        end
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check_val("drain_empty", 32'(q.size()), 32'd0);
    endtask

    logic [NW*DW-1:0] tg;
    logic [DW-1:0]    k, m;
    logic [NW-1:0]    tv;
    logic             acc;
    int               sent;

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_key = '0; i_mask = '0; i_tags = '0;
        i_tag_valid = '0; i_ready = 1'b1; i_cnt_clr = 1'b0;
        #1;
        check_val("rst_o_valid", 32'(o_valid), 32'd0);
        check_val("rst_o_ready", 32'(o_ready), 32'd1);
        check_val("rst_lookup_cnt", 32'(o_lookup_cnt), 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        idle(2);

        // Single hit in way 1.
        tg = {32'h0, 32'h0, 32'h0000_1234, 32'h0};
        step(1'b1, 32'h0000_1234, 32'hFFFF_FFFF, tg, 4'hF, 1'b1, 1'b0, acc);
        idle(1);
        check_val("single_hit_lat", 32'(o_valid), 32'd1);
        check_val("single_hit_val", 32'({o_hit, o_multi_hit, o_way_onehot, o_way_idx}),
                  32'({1'b1, 1'b0, 4'b0010, 2'd1}));
        drain();

        // Masked multi-hit, then the same with way 0 invalid.
        tg = {32'h0, 32'h0000_34FF, 32'h0, 32'hAA12_3400};
        step(1'b1, 32'h0000_3400, 32'h0000_FF00, tg, 4'hF, 1'b1, 1'b0, acc);
        step(1'b1, 32'h0000_3400, 32'h0000_FF00, tg, 4'b1110, 1'b1, 1'b0, acc);
        check_val("multi_hit_val", 32'({o_hit, o_multi_hit, o_way_onehot, o_way_idx}),
                  32'({1'b1, 1'b1, 4'b0001, 2'd0}));
        idle(1);
        check_val("way2_hit_val", 32'({o_hit, o_multi_hit, o_way_onehot, o_way_idx}),
                  32'({1'b1, 1'b0, 4'b0100, 2'd2}));
        drain();

        // Misses: all ways invalid, then no tag equal.
        step(1'b1, 32'h5, 32'hFFFF_FFFF, {4{32'h5}}, 4'h0, 1'b1, 1'b0, acc);
        step(1'b1, 32'h5, 32'hFFFF_FFFF, {32'h1, 32'h2, 32'h3, 32'h4}, 4'hF, 1'b1, 1'b0, acc);
        drain();

        // Zero mask: every valid way matches.
        step(1'b1, 32'hDEAD_BEEF, 32'h0, '0, 4'b1010, 1'b1, 1'b0, acc);
        drain();

        // Backpressure: 5 back-to-back lookups, downstream stalled cycles 3-6.
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            k = 32'(c);
            tg = {32'(c), 32'(c + 1), 32'(c + 2), 32'(c % 3)};
            step(sent < 5, 32'(sent), 32'hFFFF_FFFF, tg, 4'hF, !(c >= 3 && c <= 6), 1'b0, acc);
            if (acc) sent++;
        end
        check_val("bp_sent", 32'(sent), 32'd5);
        drain();

        // Reset with two lookups in flight.
        step(1'b1, 32'h1, 32'hFFFF_FFFF, {4{32'h1}}, 4'hF, 1'b0, 1'b0, acc);
        step(1'b1, 32'h2, 32'hFFFF_FFFF, {4{32'h2}}, 4'hF, 1'b0, 1'b0, acc);
        i_rst_n = 1'b0;
        #1;
        check_val("midrst_o_valid", 32'(o_valid), 32'd0);
        check_val("midrst_o_ready", 32'(o_ready), 32'd1);
        check_val("midrst_lookup_cnt", 32'(o_lookup_cnt), 32'd0);
        check_val("midrst_hit_cnt", 32'(o_hit_cnt), 32'd0);
        @(negedge i_clk);
        check_val("midrst_hold_ready", 32'(o_ready), 32'd1);
        i_rst_n = 1'b1;
        q.delete();
        m_lookup = 0;
        m_hit = 0;
        idle(4);

        // Saturation: 20 hits with a 4-bit counter.
        for (int i = 0; i < 20; i++)
            step(1'b1, 32'(i), 32'hFFFF_FFFF, {4{32'(i)}}, 4'hF, 1'b1, 1'b0, acc);
        drain();
        check_val("lookup_sat", 32'(o_lookup_cnt), 32'(CNT_MAX));
        check_val("hit_sat", 32'(o_hit_cnt), 32'(CNT_MAX));

        // Clear on a handshake cycle wins over the increment.
        step(1'b1, 32'h7, 32'hFFFF_FFFF, {4{32'h7}}, 4'hF, 1'b1, 1'b0, acc);
        idle(1);
        step(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, acc);
        check_val("clr_lookup_cnt", 32'(o_lookup_cnt), 32'd0);
        check_val("clr_hit_cnt", 32'(o_hit_cnt), 32'd0);
        drain();

        // Randomised traffic with random stalls and occasional clears.
        for (int c = 0; c < 400; c++) begin
            k  = $urandom;
            m  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            tv = 4'($urandom);
            for (int w = 0; w < NW; w++)
                tg[w*DW +: DW] = ($urandom_range(0, 1) == 1) ? (k ^ (32'($urandom) & ~m))
                                                             : 32'($urandom);
            step($urandom_range(0, 3) != 0, k, m, tg, tv, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tag_match_pipe
